// File: rtl/gpc_pkg.sv
// Shared definitions for the two-column GPC accumulator pipeline:
// width helpers and the S1 stage record.
package gpc_pkg;

  // Storage width of a per-column count in the S1 record; supports columns up to 255 bits.
  localparam int GPC_CNT_W = 8;

  // Smallest n such that 2**n >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width needed to hold the largest per-beat sum h0 + h1 * 2**ofs.
  function automatic int gpc_dst_w(input int h0, input int h1, input int ofs);
    return clog2(h0 + h1 * (1 << ofs) + 1);
  endfunction

  // S1 stage record: the two raw column counts plus the frame-end marker.
  typedef struct packed {
    logic [GPC_CNT_W-1:0] cnt0;
    logic [GPC_CNT_W-1:0] cnt1;
    logic                 last;
  } gpc_s1_t;

endpackage

// File: rtl/gpc_col_count.sv
// Combinational population count of one GPC column.
module gpc_col_count
  import gpc_pkg::*;
#(
  parameter int H = 3
) (
  input  logic [H-1:0]            i_bits,
  output logic [clog2(H+1)-1:0]   o_cnt
);

  localparam int CW = clog2(H + 1);

  // Sum the set bits of the column.
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < H; i++) begin
      o_cnt = o_cnt + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/gpc_pipe_acc.sv
// Two-column generalized parallel counter, two register stages, with a
// per-frame running accumulator and sticky overflow flag.
// Optional build macro: GPC_PIPE_ACC_SAT_EN -- when defined, the accumulator
// saturates at 2**ACC_W-1 on carry-out instead of wrapping.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; a stage holding valid data keeps it, unchanged, until it is taken.
module gpc_pipe_acc
  import gpc_pkg::*;
#(
  parameter  int H0    = 3,
  parameter  int H1    = 3,
  parameter  int OFS   = 2,
  parameter  int ACC_W = 8,
  localparam int DST_W = gpc_dst_w(H0, H1, OFS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [H0-1:0]     src0,
  input  logic [H1-1:0]     src1,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DST_W-1:0]  dst,
  output logic [ACC_W-1:0]  acc,
  output logic              out_last,
  output logic              ovf
);

  localparam int C0_W  = clog2(H0 + 1);
  localparam int C1_W  = clog2(H1 + 1);
  localparam int SUM_W = ACC_W + 1;

  logic             w_en1;
  logic             w_en2;
  logic [C0_W-1:0]  w_cnt0;
  logic [C1_W-1:0]  w_cnt1;
  gpc_s1_t          w_s1_next;

  logic             r_v1;
  gpc_s1_t          r_s1;

  logic             r_v2;
  logic [DST_W-1:0] r_dst;
  logic [ACC_W-1:0] r_acc;
  logic             r_last;
  logic             r_ovf;
  logic             r_frame_start;

  logic [DST_W-1:0] w_dst_next;
  logic [ACC_W-1:0] w_acc_base;
  logic             w_ovf_base;
  logic [SUM_W-1:0] w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_ovf_next;
  logic             w_unused_cnt;

  gpc_col_count #(.H(H0)) u_col0 (
    .i_bits (src0),
    .o_cnt  (w_cnt0)
  );

  gpc_col_count #(.H(H1)) u_col1 (
    .i_bits (src1),
    .o_cnt  (w_cnt1)
  );

  // Stall chain: a stage may load when it is empty or its successor loads.
  always_comb begin
    w_en2    = !r_v2 | out_ready;
    w_en1    = !r_v1 | w_en2;
    in_ready = w_en1;
  end

  // Build the S1 record from the column counts.
  always_comb begin
    w_s1_next      = '0;
    w_s1_next.cnt0 = GPC_CNT_W'(w_cnt0);
    w_s1_next.cnt1 = GPC_CNT_W'(w_cnt1);
    w_s1_next.last = in_last;
  end

  // S1 register: column counts and frame marker of the accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else if (w_en1) begin
      r_v1 <= in_valid;
      if (in_valid) r_s1 <= w_s1_next;
    end
  end

  // Upper record bits beyond the count widths are always zero.
  assign w_unused_cnt = ^{r_s1.cnt0, r_s1.cnt1};

  // Weighted beat sum and next accumulator / overflow values.
  always_comb begin
    w_dst_next = DST_W'(r_s1.cnt0) + (DST_W'(r_s1.cnt1) << OFS);
    w_acc_base = r_frame_start ? '0 : r_acc;
    w_ovf_base = r_frame_start ? 1'b0 : r_ovf;
    w_sum      = {1'b0, w_acc_base} + SUM_W'(w_dst_next);
    w_carry    = w_sum[ACC_W];
`ifdef GPC_PIPE_ACC_SAT_EN
    w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    w_acc_next = w_sum[ACC_W-1:0];
`endif
    w_ovf_next = w_ovf_base | w_carry;
  end

  // S2 register: results plus frame tracking; holds while stalled downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2          <= 1'b0;
      r_dst         <= '0;
      r_acc         <= '0;
      r_last        <= 1'b0;
      r_ovf         <= 1'b0;
      r_frame_start <= 1'b1;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_dst         <= w_dst_next;
        r_acc         <= w_acc_next;
        r_last        <= r_s1.last;
        r_ovf         <= w_ovf_next;
        r_frame_start <= r_s1.last;
      end
    end
  end

  // Output mapping.
  always_comb begin
    out_valid = r_v2;
    dst       = r_dst;
    acc       = r_acc;
    out_last  = r_last;
    ovf       = r_ovf;
  end

endmodule

// File: tb/tb_gpc_pipe_acc.sv
// Scoreboard testbench for gpc_pipe_acc (default parameters).
module tb_gpc_pipe_acc;

  localparam int H0    = 3;
  localparam int H1    = 3;
  localparam int OFS   = 2;
  localparam int ACC_W = 8;
  localparam int DST_W = 4;
  localparam int W     = 1 + 32 + DST_W + ACC_W + 2;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [H0-1:0]    src0;
  logic [H1-1:0]    src1;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DST_W-1:0] dst;
  logic [ACC_W-1:0] acc;
  logic             out_last;
  logic             ovf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int accepted = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  logic [W-1:0] exp_q[$];

  // Reference model state: frame sum as a plain integer.
  bit m_fs  = 1'b1;
  int m_acc = 0;
  bit m_ovf = 1'b0;

  bit                         stalled_prev = 1'b0;
  logic [DST_W+ACC_W+1:0]     snap;

  gpc_pipe_acc #(.H0(H0), .H1(H1), .OFS(OFS), .ACC_W(ACC_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src0      (src0),
    .src1      (src1),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dst       (dst),
    .acc       (acc),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model: runs on every accepted beat ----------------
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      int d;
      d = $countones(src0) + ($countones(src1) * (1 << OFS));
      if (m_fs) begin
        m_acc = 0;
        m_ovf = 1'b0;
      end
      m_acc = m_acc + d;
      if (m_acc > ACC_MAX) begin
        m_ovf = 1'b1;
`ifdef GPC_PIPE_ACC_SAT_EN
        m_acc = ACC_MAX;
`else
        m_acc = m_acc - (ACC_MAX + 1);
`endif
      end
      m_fs = in_last;
      accepted++;
      exp_q.push_back({(rdy_mode == 0), 32'(cyc), DST_W'(d), ACC_W'(m_acc), in_last, m_ovf});
    end
  end

  // ---------------- monitor: pops and compares each delivered result ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      stalled_prev = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got dst=%0d acc=%0d last=%0d ovf=%0d, expected no output",
                 dst, acc, out_last, ovf);
      end else begin
        logic [W-1:0]     e;
        logic [DST_W-1:0] e_dst;
        logic [ACC_W-1:0] e_acc;
        int               e_cyc;
        e     = exp_q.pop_front();
        e_dst = e[2+ACC_W +: DST_W];
        e_acc = e[2 +: ACC_W];
        e_cyc = int'(e[2+ACC_W+DST_W +: 32]);
        if (dst !== e_dst || acc !== e_acc || out_last !== e[1] || ovf !== e[0]) begin
          errors++;
          $display("FAIL result: got dst=%0d acc=%0d last=%0d ovf=%0d, expected dst=%0d acc=%0d last=%0d ovf=%0d",
                   dst, acc, out_last, ovf, e_dst, e_acc, e[1], e[0]);
        end
        if (e[W-1]) begin
          checks++;
          if (cyc - e_cyc != 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected 2", cyc - e_cyc);
          end
        end
      end
    end else if (!rst && out_valid && !out_ready) begin
      if (stalled_prev) begin
        checks++;
        if ({dst, acc, out_last, ovf} !== snap) begin
          errors++;
          $display("FAIL stall_hold: got %h, expected %h", {dst, acc, out_last, ovf}, snap);
        end
      end
      snap         = {dst, acc, out_last, ovf};
      stalled_prev = 1'b1;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [H0-1:0] s0, input logic [H1-1:0] s1,
                      input logic last, input int gap);
    int budget;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    src0     = s0;
    src1     = s1;
    in_last  = last;
    in_valid = 1'b1;
    budget   = 0;
    @(negedge clk);
    while (!in_ready) begin
      budget++;
      if (budget > 500) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", budget);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    rst      = 1'b1;
    in_valid = 1'b0;
    src0     = '0;
    src1     = '0;
    in_last  = 1'b0;
    #12;
    check_val("reset_out_valid", int'(out_valid), 0);
    check_val("reset_acc",       int'(acc), 0);
    check_val("reset_dst",       int'(dst), 0);
    check_val("reset_ovf",       int'(ovf), 0);
    check_val("reset_out_last",  int'(out_last), 0);
    check_val("reset_in_ready",  int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Sweep every source combination back to back.
    rdy_mode = 0;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      send(v[2:0], v[5:3], (i == 63), 0);
    end
    wait_drain();

    // Single-beat frame.
    send(3'b111, 3'b111, 1'b1, 0);
    wait_drain();

    // Three-beat frame of dst=10, then a fresh frame.
    send(3'b101, 3'b011, 1'b0, 0);
    send(3'b101, 3'b011, 1'b0, 0);
    send(3'b101, 3'b011, 1'b1, 0);
    send(3'b101, 3'b011, 1'b1, 0);
    wait_drain();

    // Backpressure: in_valid held high with the output blocked.
    rdy_mode  = 2;
    out_ready = 1'b0;
    n0        = accepted;
    src0      = 3'b110;
    src1      = 3'b001;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("stall_beats_captured", accepted - n0, 2);
    check_val("stall_in_ready",       int'(in_ready), 0);
    check_val("stall_out_valid",      int'(out_valid), 1);
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_drain();
    send(3'b001, 3'b000, 1'b1, 0);
    wait_drain();

    // Overflow: 20 beats of dst=15 exceed the 8-bit accumulator.
    for (int i = 0; i < 20; i++) send(3'b111, 3'b111, (i == 19), 0);
    wait_drain();

    // Asynchronous reset with two beats in flight.
    send(3'b001, 3'b010, 1'b0, 0);
    send(3'b110, 3'b101, 1'b0, 0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    m_fs  = 1'b1;
    m_acc = 0;
    m_ovf = 1'b0;
    #1;
    check_val("async_rst_out_valid", int'(out_valid), 0);
    check_val("async_rst_acc",       int'(acc), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(3'b111, 3'b111, 1'b0, 0);
    send(3'b001, 3'b000, 1'b1, 0);
    wait_drain();

    // Random traffic with random backpressure and gaps.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
    end
    send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, 0);
    rdy_mode = 0;
    wait_drain();

    check_val("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
